orao_vram_line_prefetch: RTL and testbench

//  Feeds the HDMI Orao 8K graphics display (dispAddr out / dispData in) from a shared single-port

---
 rtl/orao_vram_line_prefetch.sv | 198 +++++++++++++++++++
 tb/tb_orao_vram_line_prefetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/orao_vram_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : orao_vram_line_prefetch
// Purpose  : Two-bank 32-byte line buffer feeding the Orao graphics display
//            from shared system RAM via a req/ack read port.
// Revision : 1.0  initial release
// ============================================================================
module orao_vram_line_prefetch #(
    parameter logic [15:0] BASE_ADDR     = 16'h6000,
    parameter logic [7:0]  UNDERRUN_BYTE = 8'hAA
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [12:0] dispAddr,
    output logic [7:0]  dispData,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        underrun,
    input  logic        underrun_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_GAP   = 2'd2,
        S_NEXT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_bank0 [32];
    logic [7:0]  r_bank1 [32];
    logic [1:0]  r_tag_v;
    logic [7:0]  r_tag_line [2];
    logic        r_last_v;
    logic [7:0]  r_last_line;
    logic [7:0]  r_tgt;
    logic [4:0]  r_cnt;
    logic        r_abort;
    logic        r_l0v;
    logic [7:0]  r_l0;
    logic        r_l1v;
    logic [7:0]  r_l1;
    logic [7:0]  r_disp;
    logic        r_req;
    logic [15:0] r_addr;
    logic        r_underrun;

    logic [7:0]  w_line;
    logic [4:0]  w_byte;
    logic [7:0]  w_line_n;
    logic        w_trig;
    logic        w_fin;
    logic        w_hit;
    logic        w_res_l;
    logic        w_res_n;
    logic [7:0]  w_rd;
    logic        w_l0v;
    logic [7:0]  w_l0;
    logic        w_l1v;
    logic [7:0]  w_l1;

    assign w_line   = dispAddr[12:5];
    assign w_byte   = dispAddr[4:0];
    assign w_line_n = w_line + 8'd1;
    assign w_trig   = !r_last_v || (w_line != r_last_line);
    assign w_fin    = (r_state == S_FETCH) && mem_ack && (r_cnt == 5'd31);
    assign w_hit    = r_tag_v[w_line[0]] && (r_tag_line[w_line[0]] == w_line);
    assign w_rd     = w_line[0] ? r_bank1[w_byte] : r_bank0[w_byte];

    // Residency seen by a new target list counts a line completing this very edge.
    assign w_res_l  = w_hit || (w_fin && (r_tgt == w_line));
    assign w_res_n  = (r_tag_v[w_line_n[0]] && (r_tag_line[w_line_n[0]] == w_line_n)) ||
                      (w_fin && (r_tgt == w_line_n));

    always_comb begin
        w_l0v = r_l0v;
        w_l0  = r_l0;
        w_l1v = r_l1v;
        w_l1  = r_l1;
        if (w_trig) begin
            if (!w_res_l) begin
                w_l0v = 1'b1;
                w_l0  = w_line;
                w_l1v = !w_res_n;
                w_l1  = w_line_n;
            end else begin
                w_l0v = !w_res_n;
                w_l0  = w_line_n;
                w_l1v = 1'b0;
                w_l1  = w_line_n;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tag_v       <= 2'b00;
            r_tag_line[0] <= 8'd0;
            r_tag_line[1] <= 8'd0;
            r_last_v      <= 1'b0;
            r_last_line   <= 8'd0;
            r_tgt         <= 8'd0;
            r_cnt         <= 5'd0;
            r_abort       <= 1'b0;
            r_l0v         <= 1'b0;
            r_l0          <= 8'd0;
            r_l1v         <= 1'b0;
            r_l1          <= 8'd0;
            r_disp        <= 8'd0;
            r_req         <= 1'b0;
            r_addr        <= 16'd0;
            r_underrun    <= 1'b0;
        end else begin
            if (w_trig) begin
                r_last_v    <= 1'b1;
                r_last_line <= w_line;
            end
            r_disp <= w_hit ? w_rd : UNDERRUN_BYTE;
            if (!w_hit) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
            r_l0v <= w_l0v;
            r_l0  <= w_l0;
            r_l1v <= w_l1v;
            r_l1  <= w_l1;

            case (r_state)
                S_IDLE, S_NEXT: begin
                    if (w_l0v) begin
                        r_tgt              <= w_l0;
                        r_cnt              <= 5'd0;
                        r_abort            <= 1'b0;
                        r_tag_v[w_l0[0]]   <= 1'b0;
                        r_req              <= 1'b1;
                        r_addr             <= BASE_ADDR + {3'b000, w_l0, 5'd0};
                        r_l0v              <= w_l1v;
                        r_l0               <= w_l1;
                        r_l1v              <= 1'b0;
                        r_state            <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_req   <= 1'b0;
                        r_cnt   <= r_cnt + 5'd1;
                        r_abort <= 1'b0;
                        if (r_cnt == 5'd31) begin
                            r_tag_v[r_tgt[0]]    <= 1'b1;
                            r_tag_line[r_tgt[0]] <= r_tgt;
                            r_state              <= S_NEXT;
                        end else if (r_abort || w_trig) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end else if (w_trig) begin
                        // The outstanding byte must still be accepted before abandoning the line.
                        r_abort <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_trig) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_req   <= 1'b1;
                        r_addr  <= BASE_ADDR + {3'b000, r_tgt, r_cnt};
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pixel) begin
        if ((r_state == S_FETCH) && mem_ack) begin
            if (r_tgt[0]) begin
                r_bank1[r_cnt] <= mem_rdata;
            end else begin
                r_bank0[r_cnt] <= mem_rdata;
            end
        end
    end

    assign dispData = r_disp;
    assign mem_req  = r_req;
    assign mem_addr = r_addr;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_orao_vram_line_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_orao_vram_line_prefetch
// Purpose  : Scoreboard bench for the display line prefetcher; memory bytes
//            are modelled as addr[7:0]+0x55.
// Revision : 1.0  initial release
// ============================================================================
module tb_orao_vram_line_prefetch;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic [12:0] dispAddr;
    logic [7:0]  dispData;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        underrun;
    logic        underrun_clr;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_ack = 0;
    int          delay = 0;
    bit          tie   = 1'b1;
    bit          disp_vld = 1'b0;
    logic [15:0] eaq [$];
    logic [7:0]  edq [$];

    orao_vram_line_prefetch #(
        .BASE_ADDR    (16'h6000),
        .UNDERRUN_BYTE(8'hAA)
    ) u_dut (
        .clk_pixel   (clk_pixel),
        .rst_n       (rst_n),
        .dispAddr    (dispAddr),
        .dispData    (dispData),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .underrun    (underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Memory responder and fetch-address monitor
    int          wcnt = 0;
    bit          acked_prev = 1'b0;
    logic [15:0] hold;
    always @(negedge clk_pixel) begin
        if (!rst_n) begin
            wcnt       = 0;
            acked_prev = 1'b0;
            mem_ack    = 1'b0;
            mem_rdata  = 8'hEE;
        end else begin
            if (acked_prev) chk("req_gap", {31'd0, mem_req}, 32'd0);
            acked_prev = 1'b0;
            if (mem_req) begin
                if (wcnt == 0) hold = mem_addr;
                else chk("addr_hold", {16'd0, mem_addr}, {16'd0, hold});
                if (wcnt == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr[7:0] + 8'h55;
                    n_ack++;
                    if (eaq.size() == 0) flag("unexpected_fetch");
                    else chk("fetch_addr", {16'd0, mem_addr}, {16'd0, eaq.pop_front()});
                    wcnt       = 0;
                    acked_prev = 1'b1;
                end else begin
                    mem_ack   = tie;
                    mem_rdata = 8'hEE;
                    wcnt++;
                end
            end else begin
                if (wcnt != 0) begin
                    flag("req_withdrawn");
                    wcnt = 0;
                end
                mem_ack   = tie;
                mem_rdata = 8'hEE;
            end
        end
    end

    // Display data monitor
    always @(posedge clk_pixel) begin : mon_disp
        bit v;
        v = disp_vld;
        #1;
        if (v) begin
            if (edq.size() == 0) flag("disp_unexpected");
            else chk("dispData", {24'd0, dispData}, {24'd0, edq.pop_front()});
        end
    end

    task automatic push_line(input logic [7:0] ln, input int n);
        for (int i = 0; i < n; i++) eaq.push_back(16'h6000 + {3'b000, ln, 5'd0} + 16'(i));
    endtask

    task automatic disp_read(input logic [12:0] a, input logic [7:0] e);
        @(negedge clk_pixel);
        #2;
        dispAddr = a;
        edq.push_back(e);
        disp_vld = 1'b1;
        @(negedge clk_pixel);
        #2;
        disp_vld = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int t;
        t = 0;
        while (eaq.size() != 0 && t < maxc) begin
            @(posedge clk_pixel);
            t++;
        end
        if (eaq.size() != 0) begin
            flag("drain_timeout");
            eaq.delete();
        end
        repeat (6) @(posedge clk_pixel);
    endtask

    task automatic wait_acks(input int target, input int maxc);
        int t;
        t = 0;
        while (n_ack < target && t < maxc) begin
            @(posedge clk_pixel);
            t++;
        end
        if (n_ack < target) flag("ack_wait_timeout");
    endtask

    task automatic clr_pulse();
        @(negedge clk_pixel);
        #2;
        underrun_clr = 1'b1;
        @(negedge clk_pixel);
        #2;
        underrun_clr = 1'b0;
        @(negedge clk_pixel);
        chk("underrun_cleared", {31'd0, underrun}, 32'd0);
    endtask

    initial begin
        int base;
        rst_n        = 1'b0;
        dispAddr     = 13'h0000;
        underrun_clr = 1'b0;
        repeat (3) @(negedge clk_pixel);
        chk("rst_dispData", {24'd0, dispData}, 32'd0);
        chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);

        // Lines 0 and 1 from reset with ack tied high
        push_line(8'd0, 32);
        push_line(8'd1, 32);
        #2 rst_n = 1'b1;
        drain(1000);
        chk("t1_ack_count", n_ack, 32'd64);
        chk("t1_underrun_set", {31'd0, underrun}, 32'd1);
        clr_pulse();
        disp_read(13'h0000, 8'h55);
        disp_read(13'h0005, 8'h5A);
        disp_read(13'h001F, 8'h74);
        chk("t2_underrun", {31'd0, underrun}, 32'd0);

        // Moving to line 1 keeps it and prefetches line 2 over line 0
        push_line(8'd2, 32);
        disp_read(13'h0025, 8'h7A);
        drain(1000);
        chk("t2_underrun_after", {31'd0, underrun}, 32'd0);

        // Jump to line 255 with a clear in the same cycle as the miss
        push_line(8'd255, 32);
        push_line(8'd0, 32);
        underrun_clr = 1'b1;
        disp_read(13'h1FE0, 8'hAA);
        underrun_clr = 1'b0;
        drain(1000);
        chk("t3_underrun", {31'd0, underrun}, 32'd1);
        disp_read(13'h1FE3, 8'h38);
        push_line(8'd1, 32);
        disp_read(13'h0003, 8'h58);
        drain(1000);

        // Slow memory: three wait cycles per read
        tie   = 1'b0;
        delay = 3;
        push_line(8'd4, 32);
        push_line(8'd5, 32);
        disp_read(13'h0080, 8'hAA);
        drain(3000);
        disp_read(13'h0087, 8'hDC);
        disp_read(13'h009F, 8'hF4);

        // Line change while byte 10 of line 8 is outstanding
        base = n_ack;
        push_line(8'd8, 11);
        disp_read(13'h0100, 8'hAA);
        wait_acks(base + 10, 500);
        @(negedge clk_pixel);
        chk("t5_req_pending", {31'd0, mem_req}, 32'd0);
        push_line(8'd10, 32);
        push_line(8'd11, 32);
        disp_read(13'h0140, 8'hAA);
        drain(3000);
        disp_read(13'h0145, 8'h9A);

        // Reset in the middle of a fetch
        tie   = 1'b1;
        delay = 0;
        base  = n_ack;
        push_line(8'd20, 32);
        push_line(8'd21, 32);
        disp_read(13'h0280, 8'hAA);
        wait_acks(base + 5, 500);
        @(negedge clk_pixel);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req_drop",  {31'd0, mem_req},  32'd0);
        chk("t6_dispData",  {24'd0, dispData}, 32'd0);
        chk("t6_underrun",  {31'd0, underrun}, 32'd0);
        eaq.delete();
        dispAddr = 13'h0140;
        push_line(8'd10, 32);
        push_line(8'd11, 32);
        @(negedge clk_pixel);
        #2;
        rst_n = 1'b1;
        disp_read(13'h0140, 8'hAA);
        drain(1000);
        chk("t6_underrun_set", {31'd0, underrun}, 32'd1);
        clr_pulse();
        disp_read(13'h0141, 8'h96);
        repeat (4) @(posedge clk_pixel);
        chk("final_eaq_empty", eaq.size(), 32'd0);
        chk("final_edq_empty", edq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
